// File: rtl/audio_pkg.sv
// Shared widths, saturation limits, sample types and FSM states for the
// master output gain stage.
package audio_pkg;

  localparam int DATA_W    = 16;
  localparam int GAIN_W    = 8;
  localparam int FRAC_BITS = 4;
  localparam int PROD_W    = DATA_W + GAIN_W + 1;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1 << FRAC_BITS);

  localparam int SAT_MAX = (1 << (DATA_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DATA_W - 1));

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_L,
    ST_MUL_R,
    ST_UPDATE
  } state_t;

endpackage

// File: rtl/sat_scale.sv
// Combinational signed sample x unsigned Q4.4 gain, floor shift and
// saturation to the sample range. One instance is time-shared by L and R.
module sat_scale
  import audio_pkg::*;
(
  input  sample_t           i_sample,
  input  logic [GAIN_W-1:0] i_gain,
  output sample_t           o_result,
  output logic              o_sat
);

  localparam logic signed [PROD_W-1:0] LIM_HI = PROD_W'(SAT_MAX);
  localparam logic signed [PROD_W-1:0] LIM_LO = PROD_W'(SAT_MIN);

  logic signed [PROD_W-1:0] w_a;
  logic signed [PROD_W-1:0] w_b;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_shift;

  // Gain is zero-extended so it stays non-negative as a signed operand.
  assign w_a     = PROD_W'(i_sample);
  assign w_b     = PROD_W'($signed({1'b0, i_gain}));
  assign w_prod  = w_a * w_b;
  assign w_shift = w_prod >>> FRAC_BITS;

  always_comb begin
    o_sat    = 1'b0;
    o_result = w_shift[DATA_W-1:0];
    if (w_shift > LIM_HI) begin
      o_sat    = 1'b1;
      o_result = sample_t'(SAT_MAX);
    end else if (w_shift < LIM_LO) begin
      o_sat    = 1'b1;
      o_result = sample_t'(SAT_MIN);
    end
  end

endmodule

// File: rtl/audio_gain_stage.sv
// Master output gain stage: once per DAC frame, latch the stereo sample,
// ramp the gain one step toward the target, scale, saturate and flag clips.
module audio_gain_stage
  import audio_pkg::*;
#(
  parameter int RAMP_STEP = 1,
  parameter int CLIP_HOLD = 4800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  AUD_DACLRCK,
  input  logic [2*DATA_W-1:0]   audioIn,
  input  logic [GAIN_W-1:0]     gainTarget,
  output logic [2*DATA_W-1:0]   audioOut,
  output logic                  outValid,
  output logic [GAIN_W-1:0]     gainCur,
  output logic                  clipL,
  output logic                  clipR,
  output logic                  overrun
);

  localparam int                CNT_W = $clog2(CLIP_HOLD + 1);
  localparam logic [GAIN_W-1:0] STEP  = GAIN_W'(RAMP_STEP);
  localparam logic [CNT_W-1:0]  HOLD  = CNT_W'(CLIP_HOLD);

  logic              r_lrck_meta;
  logic              r_lrck_sync;
  logic              r_lrck_prev;
  logic              w_strobe;

  state_t            r_state;
  state_t            w_state_next;

  stereo_t           r_sample;
  logic [GAIN_W-1:0] r_gain;
  logic [GAIN_W-1:0] w_gain_next;
  logic [GAIN_W-1:0] w_gain_diff;
  sample_t           r_res_l;
  sample_t           r_res_r;
  logic [1:0]        r_sat;
  stereo_t           r_audio_out;
  logic              r_out_valid;
  logic              r_overrun;
  logic [1:0]        w_clip;

  sample_t           w_mul_in;
  sample_t           w_mul_out;
  logic              w_mul_sat;

  // Flops reset high so a frame clock already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lrck_meta <= 1'b1;
      r_lrck_sync <= 1'b1;
      r_lrck_prev <= 1'b1;
    end else begin
      r_lrck_meta <= AUD_DACLRCK;
      r_lrck_sync <= r_lrck_meta;
      r_lrck_prev <= r_lrck_sync;
    end
  end

  assign w_strobe = r_lrck_sync & ~r_lrck_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_strobe) w_state_next = ST_MUL_L;
      ST_MUL_L:  w_state_next = ST_MUL_R;
      ST_MUL_R:  w_state_next = ST_UPDATE;
      ST_UPDATE: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Step limited to the remaining distance so the ramp never overshoots.
  always_comb begin
    w_gain_diff = '0;
    w_gain_next = r_gain;
    if (gainTarget > r_gain) begin
      w_gain_diff = gainTarget - r_gain;
      w_gain_next = r_gain + ((w_gain_diff < STEP) ? w_gain_diff : STEP);
    end else if (gainTarget < r_gain) begin
      w_gain_diff = r_gain - gainTarget;
      w_gain_next = r_gain - ((w_gain_diff < STEP) ? w_gain_diff : STEP);
    end
  end

  assign w_mul_in = (r_state == ST_MUL_R) ? r_sample.r : r_sample.l;

  sat_scale u_sat_scale (
    .i_sample (w_mul_in),
    .i_gain   (r_gain),
    .o_result (w_mul_out),
    .o_sat    (w_mul_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample    <= '0;
      r_gain      <= GAIN_UNITY;
      r_res_l     <= '0;
      r_res_r     <= '0;
      r_sat       <= '0;
      r_audio_out <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_strobe) begin
            r_sample <= audioIn;
            r_gain   <= w_gain_next;
          end
        end
        ST_MUL_L: begin
          r_res_l  <= w_mul_out;
          r_sat[1] <= w_mul_sat;
        end
        ST_MUL_R: begin
          r_res_r  <= w_mul_out;
          r_sat[0] <= w_mul_sat;
        end
        ST_UPDATE: begin
          r_audio_out <= {r_res_l, r_res_r};
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
      if (w_strobe && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Index 1 is the left channel, index 0 the right.
  for (genvar gi = 0; gi < 2; gi++) begin : g_clip
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_flag;

    always_comb begin
      w_cnt_next = r_cnt;
      if (r_sat[gi]) begin
        w_cnt_next = HOLD;
      end else if (r_cnt != '0) begin
        w_cnt_next = r_cnt - CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt  <= '0;
        r_flag <= 1'b0;
      end else if (r_state == ST_UPDATE) begin
        r_cnt  <= w_cnt_next;
        r_flag <= (w_cnt_next != '0);
      end
    end

    assign w_clip[gi] = r_flag;
  end

  assign audioOut = r_audio_out;
  assign outValid = r_out_valid;
  assign gainCur  = r_gain;
  assign clipL    = w_clip[1];
  assign clipR    = w_clip[0];
  assign overrun  = r_overrun;

endmodule
